// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator: S-box init, variable-length KSA, optional drop-N, then PRGA
// feeding a single-register valid/ready output. S-box is 256x8 flops with two write ports.
//
// state | meaning
// IDLE  | waiting for a valid key_load
// INIT  | S[i] = i, one entry per cycle
// KSA   | key scheduling, one iteration per cycle
// DROP  | PRGA steps with ks_valid held low
// PRGA  | keystream output, one step per accepted byte
module rc4_keystream_gen #(
    parameter int KEY_BYTES_MAX = 32,
    parameter int DROP_N        = 0,
    parameter int LEN_W         = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_load,
    input  logic [LEN_W-1:0]           key_len,
    input  logic [8*KEY_BYTES_MAX-1:0] key_data,
    output logic                       key_err,
    output logic                       busy,
    output logic                       ks_valid,
    input  logic                       ks_ready,
    output logic [7:0]                 ks_data
);
    localparam int KIDX_W    = (KEY_BYTES_MAX > 1) ? $clog2(KEY_BYTES_MAX) : 1;
    localparam int KEY_SLOTS = 1 << KIDX_W;
    localparam int DROP_W    = 12;

    typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_KSA, ST_DROP, ST_PRGA} state_t;

    state_t              state_q, state_d;
    logic [7:0]          i_q, i_d, j_q, j_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d, klast_q, klast_d;
    logic [7:0]          key_q [KEY_SLOTS];
    logic [7:0]          key_d [KEY_SLOTS];
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                busy_q, busy_d, ks_valid_q, ks_valid_d, key_err_q, key_err_d;
    logic [7:0]          ks_data_q, ks_data_d;

    logic [7:0]          sbox_q [256];
    logic                s_we;
    logic [7:0]          s_wa0, s_wd0, s_wa1, s_wd1;

    logic                len_ok, prga_go;
    logic [KIDX_W-1:0]   klast_new;
    logic [7:0]          ksa_si, ksa_k, ksa_jn, ksa_sj;
    logic [7:0]          p_i, p_si, p_j, p_sj, p_t, p_out;

    assign len_ok    = (key_len != '0) && (key_len <= LEN_W'(KEY_BYTES_MAX));
    assign klast_new = KIDX_W'(key_len - LEN_W'(1));

    assign ksa_si = sbox_q[i_q];
    assign ksa_k  = key_q[kidx_q];
    assign ksa_jn = j_q + ksa_si + ksa_k;
    assign ksa_sj = sbox_q[ksa_jn];

    assign p_i  = i_q + 8'd1;
    assign p_si = sbox_q[p_i];
    assign p_j  = j_q + p_si;
    assign p_sj = sbox_q[p_j];
    assign p_t  = p_si + p_sj;

    // Output lookup must see the swapped S-box, so forward the two written entries.
    always_comb begin
        if (p_t == p_i)
            p_out = p_sj;
        else if (p_t == p_j)
            p_out = p_si;
        else
            p_out = sbox_q[p_t];
    end

    assign prga_go = (state_q == ST_PRGA) && (!ks_valid_q || ks_ready);

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        kidx_d     = kidx_q;
        klast_d    = klast_q;
        key_d      = key_q;
        drop_d     = drop_q;
        ks_valid_d = ks_valid_q;
        ks_data_d  = ks_data_q;
        key_err_d  = 1'b0;
        s_we       = 1'b0;
        s_wa0      = i_q;
        s_wd0      = i_q;
        s_wa1      = i_q;
        s_wd1      = i_q;

        case (state_q)
            ST_INIT: begin
                s_we = 1'b1;
                i_d  = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    state_d = ST_KSA;
                    j_d     = 8'd0;
                    kidx_d  = '0;
                end
            end
            ST_KSA: begin
                s_we   = 1'b1;
                s_wa0  = i_q;
                s_wd0  = ksa_sj;
                s_wa1  = ksa_jn;
                s_wd1  = ksa_si;
                i_d    = i_q + 8'd1;
                j_d    = ksa_jn;
                kidx_d = (kidx_q == klast_q) ? '0 : kidx_q + KIDX_W'(1);
                if (i_q == 8'hFF) begin
                    j_d = 8'd0;
                    if (DROP_N == 0) begin
                        state_d = ST_PRGA;
                    end else begin
                        state_d = ST_DROP;
                        drop_d  = DROP_W'(DROP_N);
                    end
                end
            end
            ST_DROP: begin
                s_we   = 1'b1;
                s_wa0  = p_i;
                s_wd0  = p_sj;
                s_wa1  = p_j;
                s_wd1  = p_si;
                i_d    = p_i;
                j_d    = p_j;
                drop_d = drop_q - DROP_W'(1);
                if (drop_q == DROP_W'(1))
                    state_d = ST_PRGA;
            end
            ST_PRGA: begin
                if (prga_go) begin
                    s_we       = 1'b1;
                    s_wa0      = p_i;
                    s_wd0      = p_sj;
                    s_wa1      = p_j;
                    s_wd1      = p_si;
                    i_d        = p_i;
                    j_d        = p_j;
                    ks_valid_d = 1'b1;
                    ks_data_d  = p_out;
                end
            end
            default: ;
        endcase

        // A valid key_load wins over whatever the sequence was doing.
        if (key_load) begin
            if (len_ok) begin
                state_d    = ST_INIT;
                i_d        = 8'd0;
                j_d        = 8'd0;
                kidx_d     = '0;
                klast_d    = klast_new;
                drop_d     = '0;
                ks_valid_d = 1'b0;
                for (int n = 0; n < KEY_BYTES_MAX; n++)
                    key_d[n] = key_data[8*n +: 8];
            end else begin
                key_err_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_INIT) || (state_d == ST_KSA) || (state_d == ST_DROP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            kidx_q     <= '0;
            klast_q    <= '0;
            drop_q     <= '0;
            busy_q     <= 1'b0;
            ks_valid_q <= 1'b0;
            ks_data_q  <= 8'd0;
            key_err_q  <= 1'b0;
            for (int n = 0; n < KEY_SLOTS; n++)
                key_q[n] <= 8'd0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            kidx_q     <= kidx_d;
            klast_q    <= klast_d;
            drop_q     <= drop_d;
            busy_q     <= busy_d;
            ks_valid_q <= ks_valid_d;
            ks_data_q  <= ks_data_d;
            key_err_q  <= key_err_d;
            key_q      <= key_d;
        end
    end

    // S-box contents are don't-care until INIT rewrites them, so no reset here.
    always_ff @(posedge clk) begin
        if (s_we) begin
            sbox_q[s_wa0] <= s_wd0;
            if (s_wa1 != s_wa0)
                sbox_q[s_wa1] <= s_wd1;
        end
    end

    assign busy     = busy_q;
    assign ks_valid = ks_valid_q;
    assign ks_data  = ks_data_q;
    assign key_err  = key_err_q;

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Bench for rc4_keystream_gen: known vectors, backpressure, errors, drop-3, rekey, reset
// and random keys checked against a plain RC4 model.
module tb_rc4_keystream_gen;
    localparam int KBM = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           key_load = 1'b0;
    logic           key_load2 = 1'b0;
    logic           ks_ready = 1'b1;
    logic [8:0]     key_len = '0;
    logic [8*KBM-1:0] key_data = '0;
    logic           key_err1, busy1, ks_valid1, key_err2, busy2, ks_valid2;
    logic [7:0]     ks_data1, ks_data2;

    int             n_tests = 0;
    int             n_fail = 0;
    byte unsigned   tb_key [KBM];
    int             tb_len = 1;
    byte unsigned   exp_q [$];

    rc4_keystream_gen #(.KEY_BYTES_MAX(KBM), .DROP_N(0), .LEN_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_len(key_len), .key_data(key_data),
        .key_err(key_err1), .busy(busy1), .ks_valid(ks_valid1), .ks_ready(ks_ready), .ks_data(ks_data1)
    );

    rc4_keystream_gen #(.KEY_BYTES_MAX(KBM), .DROP_N(3), .LEN_W(9)) dut_drop (
        .clk(clk), .rst_n(rst_n), .key_load(key_load2), .key_len(key_len), .key_data(key_data),
        .key_err(key_err2), .busy(busy2), .ks_valid(ks_valid2), .ks_ready(ks_ready), .ks_data(ks_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic o_valid(input int w);
        return (w != 0) ? ks_valid2 : ks_valid1;
    endfunction

    function automatic logic [7:0] o_data(input int w);
        return (w != 0) ? ks_data2 : ks_data1;
    endfunction

    // Textbook RC4 with an optional discard of the first 'skip' bytes.
    function automatic void ref_ks(input int n, input int skip);
        int s [256];
        int i, j, t;
        for (int c = 0; c < 256; c++) s[c] = c;
        j = 0;
        for (int k = 0; k < 256; k++) begin
            j = (j + s[k] + int'(tb_key[k % tb_len])) % 256;
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        exp_q.delete();
        for (int k = 0; k < n + skip; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (k >= skip) exp_q.push_back(byte'(s[(s[i] + s[j]) % 256]));
        end
    endfunction

    function automatic void set_key(input logic [63:0] v, input int len);
        tb_len = len;
        for (int n = 0; n < KBM; n++) tb_key[n] = (n < len) ? v[8*(n%8) +: 8] : 8'h00;
    endfunction

    function automatic void set_exp(input logic [127:0] v, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(v[8*(n-1-k) +: 8]);
    endfunction

    // Pulses key_load for one cycle; returns at the negedge just after the sampling edge.
    task automatic load(input int w, input int len);
        @(negedge clk);
        key_len = 9'(len);
        for (int n = 0; n < KBM; n++)
            key_data[8*n +: 8] = (n < tb_len) ? tb_key[n] : 8'($urandom);
        if (w != 0) key_load2 = 1'b1; else key_load = 1'b1;
        @(negedge clk);
        key_load  = 1'b0;
        key_load2 = 1'b0;
        key_data  = {8{$urandom}};
        key_len   = 9'($urandom);
    endtask

    task automatic wait_valid(input int w, input int exp_cyc, input string tag);
        int cyc = 0;
        ks_ready = 1'b1;
        while (!o_valid(w) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, cyc, exp_cyc);
    endtask

    task automatic collect(input int w, input int n, input bit rnd, input string tag);
        int         got = 0;
        int         cyc = 0;
        logic       stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (got < n && cyc < 4000) begin
            if (stalled) chk({tag, "_hold"}, {23'd0, o_valid(w), o_data(w)}, {23'd0, 1'b1, held});
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid(w) && ks_ready) begin
                chk($sformatf("%s_b%0d", tag, got), {24'd0, o_data(w)}, {24'd0, exp_q[got]});
                got++;
            end
            stalled = o_valid(w) && !ks_ready;
            held    = o_data(w);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_count"}, got, n);
        ks_ready = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dut", {28'd0, key_err1, busy1, ks_valid1, 1'b0} | {24'd0, ks_data1}, 32'd0);
        chk("rst_drop", {28'd0, key_err2, busy2, ks_valid2, 1'b0} | {24'd0, ks_data2}, 32'd0);
        rst_n = 1'b1;

        // Rejected key lengths
        set_key(64'h01, 1);
        load(0, 0);
        chk("err0_pulse", {30'd0, key_err1, busy1}, 32'b10);
        @(negedge clk);
        chk("err0_clear", {30'd0, key_err1, ks_valid1}, 32'd0);
        load(0, KBM + 1);
        chk("err33_pulse", {30'd0, key_err1, busy1}, 32'b10);
        repeat (10) @(negedge clk);
        chk("err_idle", {29'd0, key_err1, busy1, ks_valid1}, 32'd0);

        // "Key", full throughput, latency
        set_key(64'h79654B, 3);
        load(0, 3);
        chk("key_busy", {31'd0, busy1}, 32'd1);
        wait_valid(0, 513, "key_lat");
        chk("key_busy_off", {31'd0, busy1}, 32'd0);
        set_exp(128'hEB9F7781B734CA72A719, 10);
        collect(0, 5, 1'b0, "key");

        // Rekey with "Wiki" while "Key" is streaming
        set_key(64'h696B6957, 4);
        load(0, 4);
        chk("rekey_drop", {30'd0, ks_valid1, busy1}, 32'b01);
        wait_valid(0, 513, "wiki_lat");
        set_exp(128'h6044DB6D41B7, 6);
        collect(0, 6, 1'b0, "wiki");

        // RFC 6229 key 01..05
        set_key(64'h0504030201, 5);
        load(0, 5);
        wait_valid(0, 513, "k5_lat");
        set_exp(128'hB2396305F03DC027, 8);
        collect(0, 8, 1'b0, "k5");

        // Backpressure on "Key"
        set_key(64'h79654B, 3);
        load(0, 3);
        wait_valid(0, 513, "bp_lat");
        set_exp(128'hEB9F7781B734CA72A719, 10);
        collect(0, 10, 1'b1, "bp");

        // Drop-3 build
        set_key(64'h0504030201, 5);
        load(1, 5);
        wait_valid(1, 516, "drop_lat");
        set_exp(128'h05F03DC0, 4);
        collect(1, 4, 1'b0, "drop");

        // Asynchronous reset during KSA
        set_key(64'h79654B, 3);
        load(0, 3);
        repeat (300) @(negedge clk);
        chk("ksa_busy", {31'd0, busy1}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {28'd0, key_err1, busy1, ks_valid1, 1'b0} | {24'd0, ks_data1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_key(64'h0504030201, 5);
        load(0, 5);
        wait_valid(0, 513, "post_rst_lat");
        set_exp(128'hB2396305F03DC027, 8);
        collect(0, 8, 1'b0, "post_rst");

        // Random keys, including both length extremes
        for (int it = 0; it < 6; it++) begin
            int w;
            w = it % 2;
            tb_len = (it == 0) ? KBM : (it == 1) ? 1 : $urandom_range(1, KBM);
            for (int n = 0; n < KBM; n++) tb_key[n] = (n < tb_len) ? 8'($urandom) : 8'h00;
            load(w, tb_len);
            ref_ks(24, (w != 0) ? 3 : 0);
            wait_valid(w, (w != 0) ? 516 : 513, $sformatf("rnd%0d_lat", it));
            collect(w, 24, 1'b1, $sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rc4_keystream_gen.md
Name: rc4_keystream_gen

Overview:
Parametrised RC4 keystream generator with a register-file S-box. It performs the full RC4 sequence: S-box init, KSA with a variable key length, optional RC4-drop[n] discard, then PRGA.
- Keystream leaves through a valid/ready stream port, one byte per cycle at full throughput.
- It sits between key management (key_load) and the XOR cipher datapath, which consumes ks_data.
- Compared with the earlier block it adds variable key length, drop-N, backpressure, rekey mid-stream and a length error check.

Parameters:
KEY_BYTES_MAX, 32, maximum key length in bytes (1..256).
DROP_N, 0, number of initial PRGA bytes discarded (0..4095), i.e. RC4-drop[DROP_N].
LEN_W, 9, width of key_len; must satisfy 2^LEN_W > KEY_BYTES_MAX.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
key_load  in  1  one-cycle pulse; samples key_data and key_len, then starts (or restarts) the setup sequence.
key_len  in  LEN_W  key length in bytes, valid range 1..KEY_BYTES_MAX.
key_data  in  8*KEY_BYTES_MAX  flattened key; byte n at [8n+7:8n].
key_err  out  1  one-cycle pulse when key_load is rejected.
busy  out  1  high during INIT/KSA/DROP.
ks_valid  out  1  keystream byte available.
ks_ready  in  1  consumer accepts the byte.
ks_data  out  8  keystream byte.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, i=j=0, busy=0, ks_valid=0, ks_data=0, key_err=0, drop counter=0. S-box contents are don't-care until INIT.
- Key capture: on key_load, key_data and key_len are registered internally. Inputs may change afterwards.
- key_err: key_load with key_len=0 or key_len>KEY_BYTES_MAX is ignored, key_err pulses next cycle, state is unchanged.
- A valid key_load is accepted in any state (rekey): it drops any pending ks_valid and enters INIT on the next edge.
- FSM IDLE: waits for key_load.
- FSM INIT (256 cycles): S[c]=c for c=0..255, one entry per cycle; busy=1.
- FSM KSA (256 cycles): one iteration per cycle.
  - Key index: kidx cycles 0..key_len-1 and wraps to 0. No modulo divider.
  - jn = j + S[i] + K[kidx] (mod 256); swap S[i], S[jn]; j<=jn; i<=i+1.
  - When i==jn the swap is a no-op and S[i] keeps its value; no corruption.
  - At exit: i=0, j=0.
- FSM DROP (DROP_N cycles, skipped if DROP_N=0): PRGA steps run without asserting ks_valid.
- FSM PRGA: one step per cycle when the output register is empty or being accepted (ks_ready=1).
  - i<=i+1; j<=j+S[i+1]; swap; ks_data <= S[(S[i]+S[j]) mod 256], using post-swap values.
  - All arithmetic is 8-bit wrap-around.
- Output handshake:
  - Output is a single register. ks_valid=1 with ks_ready=0 holds ks_data stable and freezes i, j and S.
  - A transfer occurs when ks_valid&ks_ready; the next byte appears the same edge, so throughput is 1 byte/cycle.
- Latency: first ks_valid rises 512+DROP_N+1 cycles after the key_load edge (INIT+KSA+DROP+first PRGA step).
- busy: 1 from the edge after key_load until PRGA is entered; 0 in IDLE and PRGA.
- Swap with both indices in one cycle: the S-box is implemented as 256x8 flops with dual read and dual write. A same-address write (i==j) writes once.
- Reset mid-operation: immediate abort to IDLE; the captured key is not retained.

Test Plan:
- Key "Key" (4B 65 79, key_len=3), DROP_N=0, ks_ready=1 -> first 10 bytes EB 9F 77 81 B7 34 CA 72 A7 19; first ks_valid exactly 513 cycles after key_load.
- Key "Wiki" (57 69 6B 69, key_len=4) -> keystream 60 44 DB 6D 41 B7.
- Key 01 02 03 04 05 (key_len=5), DROP_N=0 -> bytes 0..7 = B2 39 63 05 F0 3D C0 27 (RFC 6229 offset 0).
- Backpressure: "Key" vector with ks_ready driven pseudo-random 50% -> ks_data stable while stalled; accepted byte stream equals the unstalled sequence; no byte lost or duplicated.
- Errors and drop: key_load with key_len=0 and with KEY_BYTES_MAX+1 -> key_err pulse, busy stays 0, no ks_valid. DROP_N=3 build with key 01..05 -> first byte 05 (4th byte of the 01..05 vector), first ks_valid 516 cycles after key_load.
- Rekey and reset: key_load("Wiki") issued mid-PRGA of "Key" -> ks_valid drops next cycle, then the "Wiki" sequence. rst_n pulsed during KSA -> outputs return to reset values asynchronously, then a fresh key_load gives the correct vector.
